mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Round-robin arbiter between an instruction-fetch port and a
//             data load/store port, serialising 32-bit big-endian word
//             accesses onto a single-port byte-wide memory (4 byte beats).
//  Ports    : mem_Clk / mem_Reset       clock, synchronous active-high reset
//             if_req/if_addr            fetch request in
//             if_valid/if_rdata         fetch completion out
//             d_req/d_we/d_addr/d_wdata data request in
//             d_valid/d_rdata           data completion out
//             m_addr/m_we/m_wdata       byte memory command out
//             m_rdata                   byte memory read data in (1-cycle)
//             busy / err                status out
//  Config   : MEM_ARB_ADDR_CHK_EN - when defined, misaligned or >64KB
//             addresses are answered immediately with err and no memory access.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter (
    input  logic        mem_Clk,
    input  logic        mem_Reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_valid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic [15:0] m_addr,
    output logic        m_we,
    output logic [7:0]  m_wdata,
    input  logic [7:0]  m_rdata,
    output logic        busy,
    output logic        err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD      = 3'd1;
    localparam logic [2:0] S_RD_TAIL = 3'd2;
    localparam logic [2:0] S_WR      = 3'd3;
    localparam logic [2:0] S_RESP    = 3'd4;

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic [1:0]  r_cnt;          // beat index within RD / WR
    logic        r_port;         // port being served: 1 = data, 0 = fetch
    logic        r_err;          // current access was rejected
    logic        r_prio_d;       // 1 = data port wins a tie next time
    logic        r_after_resp;   // first IDLE cycle following RESP
    logic [23:0] r_rshift;       // first three read bytes, oldest in [23:16]
    logic [23:0] r_wshift;       // store bytes still to be driven

    logic        w_if_req;
    logic        w_d_req;
    logic        w_grant;
    logic        w_grant_d;
    logic        w_we;
    logic        w_bad;
    logic [31:0] w_addr;

    // The port just served still has its request high in the cycle after
    // RESP (requester reacts to valid one edge later), so ignore it once.
    assign w_if_req  = if_req & ~(r_after_resp & ~r_port);
    assign w_d_req   = d_req  & ~(r_after_resp &  r_port);
    assign w_grant   = w_if_req | w_d_req;
    assign w_grant_d = w_d_req & (~w_if_req | r_prio_d);
    assign w_addr    = w_grant_d ? d_addr : if_addr;
    assign w_we      = w_grant_d & d_we;

`ifdef MEM_ARB_ADDR_CHK_EN
    assign w_bad = (w_addr[1:0] != 2'b00) | (w_addr[31:16] != 16'h0000);
`else
    logic w_unused_addr_hi;
    assign w_unused_addr_hi = ^w_addr[31:16];
    assign w_bad = 1'b0;
`endif

    // ---------------------------------------------------------------- state
    always_ff @(posedge mem_Clk) begin
        if (mem_Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    if (w_bad)     w_state_next = S_RESP;
                    else if (w_we) w_state_next = S_WR;
                    else           w_state_next = S_RD;
                end
            end
            S_RD:      if (r_cnt == 2'd3) w_state_next = S_RD_TAIL;
            S_RD_TAIL: w_state_next = S_RESP;
            S_WR:      if (r_cnt == 2'd3) w_state_next = S_RESP;
            S_RESP:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        busy     = (r_state != S_IDLE);
        m_we     = (r_state == S_WR);
        if_valid = (r_state == S_RESP) & ~r_port;
        d_valid  = (r_state == S_RESP) &  r_port;
        err      = (r_state == S_RESP) &  r_err;
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge mem_Clk) begin
        if (mem_Reset) begin
            r_cnt        <= 2'd0;
            r_port       <= 1'b0;
            r_err        <= 1'b0;
            r_prio_d     <= 1'b0;
            r_after_resp <= 1'b0;
            r_rshift     <= 24'h0;
            r_wshift     <= 24'h0;
            m_addr       <= 16'h0;
            m_wdata      <= 8'h0;
            if_rdata     <= 32'h0;
            d_rdata      <= 32'h0;
        end else begin
            r_after_resp <= (r_state == S_RESP);
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_port   <= w_grant_d;
                        r_prio_d <= ~w_grant_d;
                        r_err    <= w_bad;
                        r_cnt    <= 2'd0;
                        if (w_bad) begin
                            // Rejected read answers all-ones; rejected store
                            // leaves the load register untouched.
                            if (!w_we) begin
                                if (w_grant_d) d_rdata  <= 32'hFFFF_FFFF;
                                else           if_rdata <= 32'hFFFF_FFFF;
                            end
                        end else begin
                            m_addr <= w_addr[15:0];
                            if (w_we) begin
                                m_wdata  <= d_wdata[31:24];
                                r_wshift <= d_wdata[23:0];
                            end
                        end
                    end
                end
                S_RD: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt != 2'd3) m_addr <= m_addr + 16'd1;
                    // m_rdata lags m_addr by one cycle, so beat 0 has no data yet
                    if (r_cnt != 2'd0) r_rshift <= {r_rshift[15:0], m_rdata};
                end
                S_RD_TAIL: begin
                    if (r_port) d_rdata  <= {r_rshift, m_rdata};
                    else        if_rdata <= {r_rshift, m_rdata};
                end
                S_WR: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt != 2'd3) begin
                        m_addr   <= m_addr + 16'd1;
                        m_wdata  <= r_wshift[23:16];
                        r_wshift <= {r_wshift[15:0], 8'h00};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
